// File: rtl/video_sched_pkg.sv
// Shared types and constants for the frame-synchronous pattern scheduler.
package video_sched_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int MODE_BARS    = 0;
  localparam int MODE_SOLID   = 1;
  localparam int MODE_CHECKER = 2;
  localparam int MODE_GRAD    = 3;

  // Width of a counter that must hold values 0..n; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Normalises vsync polarity and emits a one-cycle tick on the first active cycle.
module vsync_edge_detect #(
  parameter int pol = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  output logic tick
);

  localparam logic POL = (pol != 0);

  logic sync_act;
  logic vs_q;

  always_comb begin
    sync_act = ~(vsync ^ POL);
    tick     = sync_act & ~vs_q;
  end

  // vs_q clears on reset so a vsync already active at reset exit still ticks.
  always_ff @(posedge clk) begin
    if (!reset_n) vs_q <= 1'b0;
    else          vs_q <= sync_act;
  end

endmodule

// File: rtl/video_pattern_scheduler.sv
// Selects the displayed test pattern; applies manual or auto-cycle changes at frame boundaries.
module video_pattern_scheduler
  import video_sched_pkg::*;
#(
  parameter int num_modes       = 4,
  parameter int mode_w          = 2,
  parameter int default_mode    = MODE_BARS,
  parameter int auto_dwell      = 60,
  parameter int blank_frames    = 1,
  parameter int video_vsync_pol = 0
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              video_vsync,
  input  logic              auto_enable,
  input  logic              req_valid,
  input  logic [mode_w-1:0] req_mode,
  output logic              req_ready,
  output logic              req_error,
  output logic [mode_w-1:0] cur_mode,
  output logic              mode_blank,
  output logic              switch_done,
  output logic [15:0]       frame_count
);

  localparam int DW = cnt_w(auto_dwell);
  localparam int BW = cnt_w(blank_frames);

  localparam logic [DW-1:0]     DWELL_LAST   = DW'(auto_dwell - 1);
  localparam logic [BW-1:0]     BLANK_LAST   = BW'((blank_frames > 0) ? blank_frames - 1 : 0);
  localparam logic [mode_w-1:0] DEFAULT_MODE = mode_w'(default_mode);
  localparam logic [mode_w-1:0] LAST_MODE    = mode_w'(num_modes - 1);
  localparam logic [mode_w:0]   NUM_MODES_X  = (mode_w + 1)'(num_modes);

  state_t            state;
  logic [mode_w-1:0] pend_mode;
  logic [DW-1:0]     dwell;
  logic [BW-1:0]     blank_cnt;
  logic              tick;
  logic              xfer;
  logic              req_bad;
  logic [mode_w-1:0] next_mode;

  vsync_edge_detect #(
    .pol(video_vsync_pol)
  ) u_vsync_edge (
    .clk    (pixel_clock),
    .reset_n(reset_n),
    .vsync  (video_vsync),
    .tick   (tick)
  );

  always_comb begin
    xfer      = req_valid & req_ready;
    req_bad   = ({1'b0, req_mode} >= NUM_MODES_X);
    next_mode = (cur_mode == LAST_MODE) ? '0 : cur_mode + 1'b1;
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      state       <= RUN;
      cur_mode    <= DEFAULT_MODE;
      pend_mode   <= DEFAULT_MODE;
      mode_blank  <= 1'b0;
      req_ready   <= 1'b1;
      req_error   <= 1'b0;
      switch_done <= 1'b0;
      frame_count <= '0;
      dwell       <= '0;
      blank_cnt   <= '0;
    end else begin
      req_error   <= 1'b0;
      switch_done <= 1'b0;
      if (tick) frame_count <= frame_count + 16'd1;

      unique case (state)
        RUN: begin
          // req_ready re-asserts one cycle after the switch_done that returned us here.
          req_ready <= 1'b1;
          if (xfer && !req_bad) begin
            if (req_mode == cur_mode) begin
              switch_done <= 1'b1;
              dwell       <= '0;
            end else begin
              pend_mode <= req_mode;
              req_ready <= 1'b0;
              state     <= PEND;
            end
          end else begin
            if (xfer) req_error <= 1'b1;
            if (!auto_enable) begin
              dwell <= '0;
            end else if (tick) begin
              if (dwell == DWELL_LAST) begin
                pend_mode <= next_mode;
                req_ready <= 1'b0;
                state     <= PEND;
              end else begin
                dwell <= dwell + 1'b1;
              end
            end
          end
        end

        PEND: begin
          if (tick) begin
            cur_mode <= pend_mode;
            if (blank_frames == 0) begin
              switch_done <= 1'b1;
              dwell       <= '0;
              state       <= RUN;
            end else begin
              mode_blank <= 1'b1;
              blank_cnt  <= '0;
              state      <= BLANK;
            end
          end
        end

        BLANK: begin
          if (tick) begin
            if (blank_cnt == BLANK_LAST) begin
              mode_blank  <= 1'b0;
              switch_done <= 1'b1;
              dwell       <= '0;
              state       <= RUN;
            end else begin
              blank_cnt <= blank_cnt + 1'b1;
            end
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Directed bench for video_pattern_scheduler with a switch_done scoreboard.
module tb_video_pattern_scheduler;

  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vsync;
  logic          auto_enable;
  logic          req_valid;
  logic [MW-1:0] req_mode;
  logic          req_ready;
  logic          req_error;
  logic [MW-1:0] cur_mode;
  logic          mode_blank;
  logic          switch_done;
  logic [15:0]   frame_count;

  int checks    = 0;
  int errors    = 0;
  int sd_count  = 0;
  int err_count = 0;
  logic [MW-1:0] exp_q[$];

  always #5 clk = ~clk;

  video_pattern_scheduler #(
    .num_modes      (4),
    .mode_w         (MW),
    .default_mode   (0),
    .auto_dwell     (2),
    .blank_frames   (1),
    .video_vsync_pol(0)
  ) dut (
    .pixel_clock(clk),
    .reset_n    (reset_n),
    .video_vsync(vsync),
    .auto_enable(auto_enable),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .req_error  (req_error),
    .cur_mode   (cur_mode),
    .mode_blank (mode_blank),
    .switch_done(switch_done),
    .frame_count(frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: vsync active (low) for one cycle, then inactive for three.
  task automatic frame();
    vsync = 1'b0;
    cyc(1);
    vsync = 1'b1;
    cyc(3);
  endtask

  task automatic frame_with_req(input logic [MW-1:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    vsync     = 1'b0;
    cyc(1);
    req_valid = 1'b0;
    vsync     = 1'b1;
    cyc(3);
  endtask

  task automatic request(input logic [MW-1:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    cyc(1);
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && switch_done === 1'b1) begin
      sd_count++;
      chk("sb_depth", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("switch_mode", cur_mode, exp_q.pop_front());
    end
    if (reset_n === 1'b1 && req_error === 1'b1) err_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    vsync       = 1'b1;
    auto_enable = 1'b0;
    req_valid   = 1'b0;
    req_mode    = '0;
    cyc(3);
    chk("rst_cur_mode", cur_mode, 0);
    chk("rst_blank", mode_blank, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_error", req_error, 0);
    chk("rst_done", switch_done, 0);
    chk("rst_fcount", frame_count, 0);
    reset_n = 1'b1;
    cyc(2);

    repeat (3) frame();
    chk("idle_fcount", frame_count, 3);
    chk("idle_cur_mode", cur_mode, 0);
    chk("idle_ready", req_ready, 1);

    // Manual switch to mode 2 with one blank frame.
    cyc(1);
    exp_q.push_back(3'd2);
    request(3'd2);
    chk("sw2_ready_drop", req_ready, 0);
    chk("sw2_cur_hold", cur_mode, 0);
    frame();
    chk("sw2_cur", cur_mode, 2);
    chk("sw2_blank_on", mode_blank, 1);
    chk("sw2_ready_low", req_ready, 0);
    frame();
    chk("sw2_blank_off", mode_blank, 0);
    chk("sw2_ready_back", req_ready, 1);
    chk("sw2_done_cnt", sd_count, 1);
    chk("sw2_fcount", frame_count, 5);

    // Out-of-range request.
    request(3'd5);
    chk("err_pulse", req_error, 1);
    chk("err_ready", req_ready, 1);
    chk("err_cur", cur_mode, 2);
    cyc(1);
    chk("err_clear", req_error, 0);
    chk("err_cnt", err_count, 1);
    chk("err_no_done", sd_count, 1);

    // Request for the current mode: immediate no-op completion.
    exp_q.push_back(3'd2);
    request(3'd2);
    chk("noop_done", switch_done, 1);
    chk("noop_ready", req_ready, 1);
    cyc(1);
    chk("noop_done_cnt", sd_count, 2);

    // Move to mode 3, then auto-cycle wraps 3 -> 0 after two ticks.
    exp_q.push_back(3'd3);
    request(3'd3);
    frame();
    frame();
    chk("to3_cur", cur_mode, 3);
    chk("to3_done_cnt", sd_count, 3);
    exp_q.push_back(3'd0);
    auto_enable = 1'b1;
    frame();
    chk("auto_t1_cur", cur_mode, 3);
    chk("auto_t1_ready", req_ready, 1);
    frame();
    chk("auto_t2_ready", req_ready, 0);
    chk("auto_t2_cur", cur_mode, 3);
    frame();
    chk("auto_t3_cur", cur_mode, 0);
    chk("auto_t3_blank", mode_blank, 1);
    frame();
    chk("auto_t4_blank", mode_blank, 0);
    chk("auto_t4_done_cnt", sd_count, 4);
    frame();
    chk("auto_t5_cur", cur_mode, 0);
    // Manual request on the same tick as the re-armed auto trigger wins.
    exp_q.push_back(3'd3);
    frame_with_req(3'd3);
    auto_enable = 1'b0;
    chk("race_ready", req_ready, 0);
    chk("race_cur", cur_mode, 0);
    frame();
    chk("race_cur_new", cur_mode, 3);
    frame();
    chk("race_blank_off", mode_blank, 0);
    chk("race_done_cnt", sd_count, 5);

    // Reset while blanking.
    request(3'd1);
    frame();
    chk("pre_rst_blank", mode_blank, 1);
    chk("pre_rst_cur", cur_mode, 1);
    reset_n = 1'b0;
    cyc(1);
    chk("mid_rst_cur", cur_mode, 0);
    chk("mid_rst_blank", mode_blank, 0);
    chk("mid_rst_fcount", frame_count, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_done", switch_done, 0);
    reset_n = 1'b1;
    cyc(3);
    chk("mid_rst_no_done", sd_count, 5);

    // frame_count wrap.
    force dut.frame_count = 16'hFFFF;
    cyc(1);
    release dut.frame_count;
    cyc(1);
    chk("wrap_preload", frame_count, 16'hFFFF);
    frame();
    chk("wrap_zero", frame_count, 16'h0000);
    frame();
    chk("wrap_one", frame_count, 16'h0001);

    cyc(2);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_err_cnt", err_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
